fibre_tx: RTL and testbench
===========================

Name: fibre_tx

Overview:
- Serial transmit path of the fibre-optic link, running on the bit clock.
- Each word period it samples a byte, 8b/10b-encodes it with running disparity and serialises the 10-bit symbol onto the optical driver output.
- It also emits a divide-by-10 word clock so upstream logic can update data once per symbol.
- A PRBS-7 test mode bypasses the encoder for link BER testing.

Parameters:
- None. The symbol width is fixed at 10 and the PRBS polynomial is fixed at x^7+x^6+1.

Ports:
clk_bit  input  1  bit-rate clock; all state changes on its rising edge
rst  input  1  asynchronous, active-low reset
d_in  input  8  data byte, sampled once per word period
prbs_on  input  1  1 = transmit raw PRBS-7 instead of encoded data
out  output  1  serial line bit, registered
clk_word  output  1  word clock, clk_bit/10, 50% duty

Behaviour:
- Reset (asynchronous, while rst=0):
  - out=0, clk_word=0.
  - Bit counter = 9.
  - Running disparity (RD) = negative.
  - LFSR = 7'h7F.
  - Shift register = 0.
- Bit counter:
  - Counts 0..9 and wraps 9->0 on each clk_bit rising edge.
  - clk_word=1 while the counter is 0..4 and 0 while it is 5..9; it is registered with the counter.
  - clk_word rises on the edge that loads a new symbol.
- Load (on the edge where the counter goes 9->0):
  - d_in is sampled and encoded combinationally into symbol abcdei fghj.
  - The symbol is loaded into a 10-bit shift register.
  - Bit 'a' drives out in that same cycle.
  - The following edges shift out b, c, d, e, i, f, g, h, j.
  - Latency: first symbol bit is valid on out one clk_bit edge after the sampling edge.
  - d_in must be stable in the cycle before clk_word rises.
- 8b/10b encoding (data characters only; no K codes):
  - Input bits HGF EDCBA: EDCBA = d_in[4:0] selects the 5b/6b code D.x; HGF = d_in[7:5] selects the 3b/4b code D.x.y.
  - Use the standard IEEE 802.3 tables.
  - 6b sub-block: if it is unbalanced, choose the RD- or RD+ form per the table. Sub-block RD becomes + after a 4-ones 6b code and - after a 2-ones 6b code. Neutral codes keep RD; the alternate forms of D.7 are chosen by RD.
  - 4b sub-block: encoded using the RD after the 6b sub-block, same rule.
  - D.x.P7 vs D.x.A7: use A7 (0111/1000) when RD- and x in {17,18,20}, or when RD+ and x in {11,13,14}; otherwise P7.
  - RD is updated at each load; the RD after the 4b sub-block is stored for the next symbol.
- PRBS mode:
  - prbs_on is sampled at each load edge and held for that whole word period.
  - When it is 1, out is driven each cycle from the LFSR MSB: Fibonacci LFSR s[6:0], shifting in s[6]^s[5] every clk_bit edge.
  - The LFSR runs only while in PRBS mode.
  - The encoder and RD are frozen during PRBS words.
  - Switching modes takes effect only at a word boundary; a partial symbol is never emitted.
- Boundary and async cases:
  - rst asserted mid-symbol: the symbol is aborted immediately and out=0.
  - After rst is released, the first rising edge loads a symbol (the counter is at 9).
  - d_in changes mid-word: ignored until the next load.

Test Plan:
- Reset, then d_in=0x00 held -> out repeats 1,0,0,1,1,1,0,1,0,0 every 10 clocks (D0.0 at RD-, RD stays -); clk_word period 10 clk_bit with 5 high/5 low.
- d_in=0xB5 (D21.5) held -> out = 1010101010 every word, regardless of RD.
- Ramp: d_in incremented every 10 bit times, 0x00..0xFF -> decoding each symbol with a reference 8b/10b decoder returns the ramp. Running disparity of the bit stream never leaves ±1 at symbol boundaries, no run exceeds 5, and no disparity errors occur.
- Check symbols at the A7 boundaries: D17.7 at RD- and D11.7 at RD+ -> A7 form; D17.7 at RD+ -> P7 form.
- prbs_on=1 for ≥127 bits -> out is periodic with period 127 and contains 64 ones, a run of 7 ones and a run of 6 zeros. prbs_on toggled mid-word -> the change takes effect at the next clk_word rise.
- rst pulled low mid-symbol -> out=0 and clk_word=0 immediately. After release, the first symbol is encoded from RD-.

Source files
------------

// File: rtl/fibre_tx_if.sv
// Parallel-side link bundle of the fibre transmitter: byte/mode inputs and
// the serial line and word-clock outputs.
interface fibre_tx_if;
  logic [7:0] d_in;
  logic       prbs_on;
  logic       out;
  logic       clk_word;

  modport master (output d_in, output prbs_on, input out, input clk_word);
  modport slave  (input d_in, input prbs_on, output out, output clk_word);
endinterface

// File: rtl/fibre_tx.sv
// Bit-clock serial transmitter: 8b/10b encoder with running disparity, 10:1
// serialiser, divide-by-10 word clock and a PRBS-7 test-pattern bypass.
module fibre_tx (
  input  logic      clk_bit,
  input  logic      rst,
  fibre_tx_if.slave lnk
);

  typedef enum logic {MODE_DATA, MODE_PRBS} mode_e;

  // 5b/6b codes in their RD- form, bit order abcdei from MSB
  function automatic logic [5:0] code6(input logic [4:0] x);
    case (x)
      5'd0:  code6 = 6'b100111;  5'd1:  code6 = 6'b011101;
      5'd2:  code6 = 6'b101101;  5'd3:  code6 = 6'b110001;
      5'd4:  code6 = 6'b110101;  5'd5:  code6 = 6'b101001;
      5'd6:  code6 = 6'b011001;  5'd7:  code6 = 6'b111000;
      5'd8:  code6 = 6'b111001;  5'd9:  code6 = 6'b100101;
      5'd10: code6 = 6'b010101;  5'd11: code6 = 6'b110100;
      5'd12: code6 = 6'b001101;  5'd13: code6 = 6'b101100;
      5'd14: code6 = 6'b011100;  5'd15: code6 = 6'b010111;
      5'd16: code6 = 6'b011011;  5'd17: code6 = 6'b100011;
      5'd18: code6 = 6'b010011;  5'd19: code6 = 6'b110010;
      5'd20: code6 = 6'b001011;  5'd21: code6 = 6'b101010;
      5'd22: code6 = 6'b011010;  5'd23: code6 = 6'b111010;
      5'd24: code6 = 6'b110011;  5'd25: code6 = 6'b100110;
      5'd26: code6 = 6'b010110;  5'd27: code6 = 6'b110110;
      5'd28: code6 = 6'b001110;  5'd29: code6 = 6'b101110;
      5'd30: code6 = 6'b011110;  default: code6 = 6'b101011;
    endcase
  endfunction

  // 3b/4b codes in their RD- form (primary D.x.P7 for y=7), bit order fghj
  function automatic logic [3:0] code4(input logic [2:0] y);
    case (y)
      3'd0: code4 = 4'b1011;  3'd1: code4 = 4'b1001;
      3'd2: code4 = 4'b0101;  3'd3: code4 = 4'b1100;
      3'd4: code4 = 4'b1101;  3'd5: code4 = 4'b1010;
      3'd6: code4 = 4'b0110;  default: code4 = 4'b1110;
    endcase
  endfunction

  // Returns {rd_after, abcdei, fghj}. The RD+ form of every unbalanced code
  // (and of the balanced D.7 / D.x.3 alternates) is the bitwise complement.
  function automatic logic [10:0] enc8b10b(input logic [7:0] d, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       bal6, bal4, rd6, a7;
    x    = d[4:0];
    y    = d[7:5];
    c6   = code6(x);
    bal6 = ($countones(c6) == 3);
    if (rd && (!bal6 || x == 5'd7)) c6 = ~c6;
    rd6  = bal6 ? rd : ~rd;
    a7   = (y == 3'd7) &&
           ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
            ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    c4   = a7 ? 4'b0111 : code4(y);
    bal4 = ($countones(c4) == 2);
    if (rd6 && (!bal4 || y == 3'd3)) c4 = ~c4;
    enc8b10b = {(bal4 ? rd6 : ~rd6), c6, c4};
  endfunction

  logic [3:0]  cnt_q, cnt_d;
  logic        clk_word_q, clk_word_d;
  logic        out_q, out_d;
  logic [9:0]  shreg_q, shreg_d;
  logic        rd_q, rd_d;
  logic [6:0]  lfsr_q, lfsr_d;
  mode_e       mode_q, mode_d;
  logic        load;
  logic [10:0] enc;

  assign load = (cnt_q == 4'd9);
  assign enc  = enc8b10b(lnk.d_in, rd_q);

  always_comb begin
    cnt_d      = load ? 4'd0 : cnt_q + 4'd1;
    clk_word_d = (cnt_d < 4'd5);
    mode_d     = load ? (lnk.prbs_on ? MODE_PRBS : MODE_DATA) : mode_q;
    shreg_d    = {shreg_q[8:0], 1'b0};
    out_d      = shreg_q[9];
    rd_d       = rd_q;
    lfsr_d     = lfsr_q;
    // The mode of the word being started decides the source, so a mode
    // change only lands on a word boundary.
    if (mode_d == MODE_PRBS) begin
      out_d  = lfsr_q[6];
      lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end else if (load) begin
      out_d   = enc[9];
      shreg_d = {enc[8:0], 1'b0};
      rd_d    = enc[10];
    end
  end

  always_ff @(posedge clk_bit or negedge rst) begin
    if (!rst) begin
      cnt_q      <= 4'd9;
      clk_word_q <= 1'b0;
      out_q      <= 1'b0;
      shreg_q    <= 10'd0;
      rd_q       <= 1'b0;
      lfsr_q     <= 7'h7F;
      mode_q     <= MODE_DATA;
    end else begin
      cnt_q      <= cnt_d;
      clk_word_q <= clk_word_d;
      out_q      <= out_d;
      shreg_q    <= shreg_d;
      rd_q       <= rd_d;
      lfsr_q     <= lfsr_d;
      mode_q     <= mode_d;
    end
  end

  assign lnk.out      = out_q;
  assign lnk.clk_word = clk_word_q;

endmodule

// File: tb/tb_fibre_tx.sv
// Randomised self-checking bench for fibre_tx against a table-driven 8b/10b
// reference model, a reference decoder and line-level disparity/run checks.
module tb_fibre_tx;

  logic clk_bit = 1'b0;
  logic rst;
  fibre_tx_if lnk ();

  fibre_tx dut (.clk_bit(clk_bit), .rst(rst), .lnk(lnk));

  always #5 clk_bit = ~clk_bit;

  int checks = 0;
  int errors = 0;

  // Full 802.3 data tables, both disparity columns written out explicitly
  bit [5:0] c6m [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001,
                         6'b110101, 6'b101001, 6'b011001, 6'b111000,
                         6'b111001, 6'b100101, 6'b010101, 6'b110100,
                         6'b001101, 6'b101100, 6'b011100, 6'b010111,
                         6'b011011, 6'b100011, 6'b010011, 6'b110010,
                         6'b001011, 6'b101010, 6'b011010, 6'b111010,
                         6'b110011, 6'b100110, 6'b010110, 6'b110110,
                         6'b001110, 6'b101110, 6'b011110, 6'b101011};
  bit [5:0] c6p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001,
                         6'b001010, 6'b101001, 6'b011001, 6'b000111,
                         6'b000110, 6'b100101, 6'b010101, 6'b110100,
                         6'b001101, 6'b101100, 6'b011100, 6'b101000,
                         6'b100100, 6'b100011, 6'b010011, 6'b110010,
                         6'b001011, 6'b101010, 6'b011010, 6'b000101,
                         6'b001100, 6'b100110, 6'b010110, 6'b001001,
                         6'b001110, 6'b010001, 6'b100001, 6'b010100};
  bit [3:0] c4m [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                        4'b1101, 4'b1010, 4'b0110, 4'b1110};
  bit [3:0] c4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                        4'b0010, 4'b1010, 4'b0110, 4'b0001};

  logic       rd_m;
  logic [6:0] lfsr_m;

  function automatic logic [9:0] model_enc(input logic [7:0] d);
    logic [5:0] s6;
    logic [3:0] s4;
    int x, y;
    x  = int'(d[4:0]);
    y  = int'(d[7:5]);
    s6 = rd_m ? c6p[x] : c6m[x];
    if ($countones(s6) != 3) rd_m = ~rd_m;
    if (y == 7 && ((!rd_m && (x == 17 || x == 18 || x == 20)) ||
                   ( rd_m && (x == 11 || x == 13 || x == 14))))
      s4 = rd_m ? 4'b1000 : 4'b0111;
    else
      s4 = rd_m ? c4p[y] : c4m[y];
    if ($countones(s4) != 2) rd_m = ~rd_m;
    return {s6, s4};
  endfunction

  function automatic logic [9:0] model_prbs();
    logic [9:0] w;
    for (int k = 0; k < 10; k++) begin
      w      = {w[8:0], lfsr_m[6]};
      lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
    end
    return w;
  endfunction

  function automatic int decode(input logic [9:0] s);
    int x, y;
    x = -1;
    y = -1;
    for (int i = 0; i < 32; i++)
      if (s[9:4] == c6m[i] || s[9:4] == c6p[i]) x = i;
    for (int j = 0; j < 8; j++)
      if (s[3:0] == c4m[j] || s[3:0] == c4p[j]) y = j;
    if (s[3:0] == 4'b0111 || s[3:0] == 4'b1000) y = 7;
    if (x < 0 || y < 0) return -1;
    return y * 32 + x;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    lnk.d_in = 8'h00;
    lnk.prbs_on = 1'b0;
    repeat (3) @(negedge clk_bit);
    rd_m = 1'b0;
    lfsr_m = 7'h7F;
    rst = 1'b1;
  endtask

  // One word period: drive inputs before the load edge, perturb them mid-word
  task automatic run_word(input logic [7:0] d, input logic p, input logic mid_p,
                          output logic [9:0] sym);
    logic [9:0] exp_w, s;
    s = '0;
    lnk.d_in = d;
    lnk.prbs_on = p;
    exp_w = p ? model_prbs() : model_enc(d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_bit);
      s = {s[8:0], lnk.out};
      checks++;
      if (lnk.clk_word !== 1'(i < 5)) begin
        errors++;
        $display("FAIL clk_word bit%0d: got %b expected %b", i, lnk.clk_word, 1'(i < 5));
      end
      if (i == 4) begin
        lnk.d_in = 8'($urandom);
        lnk.prbs_on = mid_p;
      end
    end
    checks++;
    if (s !== exp_w) begin
      errors++;
      $display("FAIL word d=%02h prbs=%b: got %b expected %b", d, p, s, exp_w);
    end
    sym = s;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    @(negedge clk_bit);
    checks++;
    if (lnk.out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", lnk.out); end
    checks++;
    if (lnk.clk_word !== 1'b0) begin errors++; $display("FAIL reset_clk_word: got %b expected 0", lnk.clk_word); end
    rst = 1'b1;
  endtask

  task automatic test_d00();
    logic [9:0] s;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      run_word(8'h00, 1'b0, 1'b0, s);
      checks++;
      if (s !== 10'b1001110100) begin errors++; $display("FAIL d00 word%0d: got %b expected 1001110100", n, s); end
    end
  endtask

  task automatic test_d21_5();
    logic [9:0] s;
    do_reset();
    run_word(8'hB5, 1'b0, 1'b0, s);
    checks++;
    if (s !== 10'b1010101010) begin errors++; $display("FAIL d21_5 rd-: got %b expected 1010101010", s); end
    run_word(8'h20, 1'b0, 1'b0, s);
    run_word(8'hB5, 1'b0, 1'b0, s);
    checks++;
    if (s !== 10'b1010101010) begin errors++; $display("FAIL d21_5 rd+: got %b expected 1010101010", s); end
  endtask

  task automatic test_a7();
    logic [9:0] s;
    do_reset();
    run_word(8'hF1, 1'b0, 1'b0, s);
    checks++;
    if (s !== 10'b1000110111) begin errors++; $display("FAIL a7 D17.7 rd-: got %b expected 1000110111", s); end
    run_word(8'hEB, 1'b0, 1'b0, s);
    checks++;
    if (s !== 10'b1101001000) begin errors++; $display("FAIL a7 D11.7 rd+: got %b expected 1101001000", s); end
    run_word(8'h20, 1'b0, 1'b0, s);
    run_word(8'hF1, 1'b0, 1'b0, s);
    checks++;
    if (s !== 10'b1000110001) begin errors++; $display("FAIL p7 D17.7 rd+: got %b expected 1000110001", s); end
  endtask

  task automatic test_ramp();
    logic [9:0] s;
    int disp, run, maxrun, dec;
    logic last;
    do_reset();
    disp = -1; run = 0; maxrun = 0; last = 1'b0;
    for (int v = 0; v < 256; v++) begin
      run_word(8'(v), 1'b0, 1'b0, s);
      dec = decode(s);
      checks++;
      if (dec != v) begin errors++; $display("FAIL ramp decode: got %0d expected %0d", dec, v); end
      for (int k = 9; k >= 0; k--) begin
        disp += s[k] ? 1 : -1;
        run = (run > 0 && s[k] == last) ? run + 1 : 1;
        last = s[k];
        if (run > maxrun) maxrun = run;
      end
      checks++;
      if (disp != (rd_m ? 1 : -1)) begin
        errors++;
        $display("FAIL ramp disparity at %0d: got %0d expected %0d", v, disp, rd_m ? 1 : -1);
      end
    end
    checks++;
    if (maxrun > 5) begin errors++; $display("FAIL ramp run length: got %0d expected <=5", maxrun); end
  endtask

  task automatic test_random();
    logic [9:0] s;
    do_reset();
    for (int n = 0; n < 150; n++)
      run_word(8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), s);
  endtask

  task automatic test_prbs();
    logic [9:0] s;
    logic bits [260];
    int ones, cur, max1, max0, per_err;
    do_reset();
    for (int w = 0; w < 26; w++) begin
      run_word(8'($urandom), 1'b1, 1'b1, s);
      for (int k = 0; k < 10; k++) bits[w * 10 + k] = s[9 - k];
    end
    per_err = 0;
    for (int i = 0; i < 133; i++) if (bits[i] !== bits[i + 127]) per_err++;
    checks++;
    if (per_err != 0) begin errors++; $display("FAIL prbs period: got %0d differing bits expected 0", per_err); end
    ones = 0;
    for (int i = 0; i < 127; i++) if (bits[i]) ones++;
    checks++;
    if (ones != 64) begin errors++; $display("FAIL prbs ones: got %0d expected 64", ones); end
    cur = 0; max1 = 0; max0 = 0;
    for (int i = 0; i < 254; i++) begin
      cur = (i > 0 && bits[i] == bits[i - 1]) ? cur + 1 : 1;
      if (bits[i] && cur > max1) max1 = cur;
      if (!bits[i] && cur > max0) max0 = cur;
    end
    checks++;
    if (max1 != 7) begin errors++; $display("FAIL prbs run1: got %0d expected 7", max1); end
    checks++;
    if (max0 != 6) begin errors++; $display("FAIL prbs run0: got %0d expected 6", max0); end
    run_word(8'h00, 1'b0, 1'b0, s);
  endtask

  task automatic test_mode_switch();
    logic [9:0] s;
    run_word(8'h55, 1'b0, 1'b1, s);
    run_word(8'h3C, 1'b1, 1'b0, s);
    run_word(8'hC3, 1'b0, 1'b0, s);
    run_word(8'h7E, 1'b1, 1'b0, s);
    run_word(8'h81, 1'b0, 1'b1, s);
  endtask

  task automatic test_reset_midsymbol();
    logic [9:0] s;
    do_reset();
    run_word(8'h20, 1'b0, 1'b0, s);
    lnk.d_in = 8'h00;
    repeat (2) @(negedge clk_bit);
    checks++;
    if (lnk.out !== 1'b1) begin errors++; $display("FAIL midsym pre-reset out: got %b expected 1", lnk.out); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (lnk.out !== 1'b0) begin errors++; $display("FAIL midsym reset out: got %b expected 0", lnk.out); end
    checks++;
    if (lnk.clk_word !== 1'b0) begin errors++; $display("FAIL midsym reset clk_word: got %b expected 0", lnk.clk_word); end
    repeat (2) @(negedge clk_bit);
    rd_m = 1'b0;
    lfsr_m = 7'h7F;
    rst = 1'b1;
    run_word(8'h20, 1'b0, 1'b0, s);
    checks++;
    if (s !== 10'b1001111001) begin errors++; $display("FAIL midsym first word: got %b expected 1001111001", s); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    lnk.d_in = 8'h00;
    lnk.prbs_on = 1'b0;
    rd_m = 1'b0;
    lfsr_m = 7'h7F;
    test_reset();
    test_d00();
    test_d21_5();
    test_a7();
    test_ramp();
    test_random();
    test_prbs();
    test_mode_switch();
    test_reset_midsymbol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
